// File: rtl/status_cond_unit.sv
// Condition-flag register for the EX stage plus condition-code evaluation for the ID instruction.
// The EX flag result is forwarded so the next instruction can test it without a bubble.
module status_cond_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ex_valid,
  input  logic [3:0] ex_opcode,
  input  logic       ex_s,
  input  logic       ex_is_dp,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       shifter_carry,
  input  logic [3:0] id_cond,
  input  logic       stall,
  input  logic       flush,
  output logic [3:0] flags_q,
  output logic       carry_to_alu,
  output logic       cond_pass_ex,
  output logic       cond_pass_id
);

  logic [3:0] flags_d;
  logic [3:0] next_flags;
  logic [3:0] eff_flags;
  logic       cond_pass_ex_q;
  logic       cond_pass_ex_d;
  logic       is_arith;
  logic       is_compare;
  logic       wr;
  logic       f_n, f_z, f_c, f_v;

  // Arithmetic: SUB RSB ADD ADC SBC RSC (0010-0111) and CMP CMN (1010-1011).
  always_comb begin
    is_arith = (ex_opcode[3:1] == 3'b001) || (ex_opcode[3:2] == 2'b01) ||
               (ex_opcode[3:1] == 3'b101);
    is_compare = (ex_opcode[3:2] == 2'b10);
    wr = ex_valid & ex_is_dp & cond_pass_ex_q & (ex_s | is_compare);
  end

  always_comb begin
    next_flags = flags_q;
    if (wr) begin
      if (is_arith) begin
        next_flags = {alu_n, alu_z, alu_c, alu_v};
      end else begin
        next_flags = {alu_n, alu_z, shifter_carry, flags_q[0]};
      end
    end
    eff_flags = wr ? next_flags : flags_q;
    flags_d   = eff_flags;
  end

  always_comb begin
    {f_n, f_z, f_c, f_v} = eff_flags;
    cond_pass_id = 1'b0;
    unique case (id_cond)
      4'b0000: cond_pass_id = f_z;
      4'b0001: cond_pass_id = !f_z;
      4'b0010: cond_pass_id = f_c;
      4'b0011: cond_pass_id = !f_c;
      4'b0100: cond_pass_id = f_n;
      4'b0101: cond_pass_id = !f_n;
      4'b0110: cond_pass_id = f_v;
      4'b0111: cond_pass_id = !f_v;
      4'b1000: cond_pass_id = f_c & !f_z;
      4'b1001: cond_pass_id = !f_c | f_z;
      4'b1010: cond_pass_id = (f_n == f_v);
      4'b1011: cond_pass_id = (f_n != f_v);
      4'b1100: cond_pass_id = !f_z & (f_n == f_v);
      4'b1101: cond_pass_id = f_z | (f_n != f_v);
      4'b1110: cond_pass_id = 1'b1;
      4'b1111: cond_pass_id = 1'b0;
      default: cond_pass_id = 1'b0;
    endcase
  end

  always_comb begin
    cond_pass_ex_d = cond_pass_id;
    if (flush) begin
      cond_pass_ex_d = 1'b0;
    end else if (stall) begin
      cond_pass_ex_d = cond_pass_ex_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q        <= FLAG_RESET;
      cond_pass_ex_q <= 1'b0;
    end else begin
      flags_q        <= flags_d;
      cond_pass_ex_q <= cond_pass_ex_d;
    end
  end

  assign cond_pass_ex = cond_pass_ex_q;
  assign carry_to_alu = flags_q[1];

endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Holds the architectural condition flags (N, Z, C, V) downstream of the ALU and Shifter in the EX stage.
- Decides which flags each EX instruction updates.
- Evaluates the 4-bit condition field of the instruction in ID against the flags it will see, forwarding the EX result when needed.
- Registers the pass/fail verdict into EX and supplies the carry-in to the ALU.

Parameters:
- FLAG_RESET, 4'b0000, reset value of {N,Z,C,V}.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  a real instruction occupies EX (0 = bubble).
- ex_opcode  input  4  data-processing opcode of the EX instruction (ALU opCode encoding).
- ex_s  input  1  S bit of the EX instruction.
- ex_is_dp  input  1  EX instruction is data-processing (0 = load/store/branch; never writes flags).
- alu_n, alu_z, alu_c, alu_v  input  1 each  ALU flag outputs for the EX instruction.
- shifter_carry  input  1  Shifter carry-out for the EX instruction.
- id_cond  input  4  condition field (I31-I28) of the ID instruction.
- stall  input  1  hold ID->EX; cond_pass_ex keeps its value.
- flush  input  1  kill the ID instruction moving into EX.
- flags_q  output  4  registered {N,Z,C,V}.
- carry_to_alu  output  1  equals flags_q[1] (C); drives the ALU carryIn.
- cond_pass_ex  output  1  registered verdict for the instruction now in EX.
- cond_pass_id  output  1  combinational verdict for the ID instruction (debug/branch use).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - flags_q=FLAG_RESET.
  - cond_pass_ex=0.
  - Takes effect immediately, including mid-stall or mid-flush.
- Flag write enable:
  - wr = ex_valid & ex_is_dp & cond_pass_ex & (ex_s | ex_opcode[3:2]==2'b10).
  - TST/TEQ/CMP/CMN always write flags regardless of ex_s.
- Next-flag selection:
  - Arithmetic ops (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN): {N,Z,C,V} = {alu_n, alu_z, alu_c, alu_v}.
  - Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): N=alu_n, Z=alu_z, C=shifter_carry, V=flags_q V (preserved). ALU cFlag/vFlag are ignored for these ops.
- Flag register update:
  - When wr=1, flags_q <= next flags at the rising edge.
  - When wr=0, flags_q holds.
  - The flag write is independent of stall: EX completes even when ID stalls.
- Forwarding:
  - eff_flags = wr ? next flags : flags_q.
  - cond_pass_id is evaluated on eff_flags, so a flag-setting instruction in EX is seen by the dependent instruction in ID in the same cycle. No bubble is needed.
- Condition decode (cond_pass_id):
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 MI: N.
  - 0101 PL: !N.
  - 0110 VS: V.
  - 0111 VC: !V.
  - 1000 HI: C & !Z.
  - 1001 LS: !C | Z.
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: !Z & (N==V).
  - 1101 LE: Z | (N!=V).
  - 1110 AL: 1.
  - 1111: 0 (reserved; treated as never).
- cond_pass_ex register, priority flush > stall:
  - flush=1: 0.
  - else stall=1: hold.
  - else: cond_pass_id.
- A failed-condition instruction in EX writes no flags. Result/register writeback gating is the control unit's job, driven from cond_pass_ex.
- carry_to_alu has zero latency from flags_q. ADC/SBC/RSC in EX see the flags written by the immediately preceding instruction, because that write completed at the previous edge.
- Bubbles (ex_valid=0) and non-DP instructions never modify flags_q, whatever the ALU outputs show.
- No X propagation: unused ALU flag inputs are never sampled unless wr=1.

Test Plan:
- Reset, then release → flags_q=0000, cond_pass_ex=0, carry_to_alu=0. Assert reset_n low mid-run → outputs return to these values immediately, without a clock edge.
- EX CMP with ex_s=0, alu {N,Z,C,V}=0100, ID cond=0000 (EQ) → cond_pass_id=1 in the same cycle (forwarded); next edge flags_q=0100, cond_pass_ex=1.
- EX MOVS with shifter_carry=1, alu_c=0, alu_v=1, prior flags_q=0001 → flags_q=0011 (C from shifter, V preserved).
- ADDS with ex_valid=1 but cond_pass_ex=0, alu flags 1111 → flags_q unchanged. Repeat with ex_valid=0 → flags_q unchanged.
- flags_q=1001 (N=1, V=1); sweep id_cond 0-15 → GE=1, LT=0, GT=1, LE=0, MI=1, VS=1, AL=1, 1111=0.
- cond_pass_ex=1 with stall=1 for 2 cycles while id_cond changes to a failing code → cond_pass_ex holds 1. Then assert stall=1 and flush=1 together → cond_pass_ex=0 at the next edge.
